// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_pkg
// Description : Shared definitions for the memory access stage. This file
//               provides the opcode constants, the FSM state encoding, the
//               default data width, and a helper that identifies memory
//               opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

  localparam int DEF_DATA_W = 32;

  // Major opcode field, instruction bits [31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WB     = 2'd2
  } state_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Memory stage that sits behind the ALU.
//               - lw/sw instructions go to data memory over a req/ack bus.
//               - R-type ALU results are forwarded to register-file writeback.
//               - Only one transaction is in flight at a time.
//               - The upstream interface uses valid/ready handshaking.
// Ports       : clk, rst_n             clock, async active-low reset
//               in_valid/in_ready      upstream handshake
//               in_inst                instruction word (op, rt, rd fields)
//               in_result, in_rt_val   effective address / ALU result, store data
//               mem_req/we/addr/wdata  memory request, held until mem_ack
//               mem_ack, mem_rdata     memory completion and load data
//               wb_valid/reg/data      one-cycle register writeback strobe
//               err                    one-cycle misalignment/timeout pulse
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [DATA_W-1:0] in_result,
  input  logic [DATA_W-1:0] in_rt_val,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_we;
  logic [4:0]          r_rt;
  logic [DATA_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_wb_valid;
  logic [4:0]          r_wb_reg;
  logic [DATA_W-1:0]   r_wb_data;
  logic                r_err;

  logic [5:0]          w_op;
  logic [4:0]          w_rt;
  logic [4:0]          w_rd;
  logic                w_accept;
  logic                w_aligned;
  logic                w_expire;
  logic                w_unused_inst;

  assign w_op      = in_inst[31:26];
  assign w_rt      = in_inst[20:16];
  assign w_rd      = in_inst[15:11];
  assign w_accept  = in_valid && (r_state == ST_IDLE);
  assign w_aligned = (in_result[1:0] == 2'b00);
  // Final cycle of the ACCESS window; an ack in this cycle still completes.
  assign w_expire  = (r_cnt == CNT_LAST);
  assign w_unused_inst = ^{in_inst[25:21], in_inst[10:0]};

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and state-decoded outputs. mem_req decodes straight from the
  // state register, so an asynchronous reset drops it at once.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    mem_req      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (w_accept && is_mem_op(w_op) && w_aligned) begin
          w_state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          w_state_next = r_we ? ST_IDLE : ST_WB;
        end else if (w_expire) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_WB: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: request latches, access timer, writeback and error strobes
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_rt       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wb_valid <= 1'b0;
      r_wb_reg   <= '0;
      r_wb_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_err      <= 1'b0;

      if (w_accept) begin
        case (w_op)
          OP_RTYPE: begin
            // Writes to r0 are discarded, so no strobe is raised.
            if (w_rd != 5'd0) begin
              r_wb_valid <= 1'b1;
              r_wb_reg   <= w_rd;
              r_wb_data  <= in_result;
            end
          end
          OP_LW, OP_SW: begin
            if (!w_aligned) begin
              r_err <= 1'b1;
            end else begin
              r_addr  <= in_result;
              r_wdata <= in_rt_val;
              r_we    <= (w_op == OP_SW);
              r_rt    <= w_rt;
              r_cnt   <= '0;
            end
          end
          default: begin
            // Unknown opcodes are consumed without any effect.
          end
        endcase
      end

      if (r_state == ST_ACCESS) begin
        if (mem_ack) begin
          r_cnt <= '0;
          // Load data is captured here and presented during the WB state.
          if (!r_we && (r_rt != 5'd0)) begin
            r_wb_valid <= 1'b1;
            r_wb_reg   <= r_rt;
            r_wb_data  <= mem_rdata;
          end
        end else if (w_expire) begin
          r_cnt <= '0;
          r_err <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign wb_valid  = r_wb_valid;
  assign wb_reg    = r_wb_reg;
  assign wb_data   = r_wb_data;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit. Single-cycle
//               instructions come from a vector table, and memory
//               transactions are hand-sequenced. Every expected writeback or
//               error event goes into a scoreboard queue. A negedge monitor
//               pops that queue whenever the DUT raises wb_valid or err.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_inst;
  logic [DATA_W-1:0] in_result;
  logic [DATA_W-1:0] in_rt_val;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              wb_valid;
  logic [4:0]        wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic              err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          is_err;
    logic [4:0]  rg;
    logic [31:0] data;
  } event_t;

  event_t sb_q[$];

  typedef struct {
    logic [31:0] inst;
    logic [31:0] result;
    logic [31:0] rt_val;
    bit          exp_wb;
    bit          exp_err;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
  } vec_t;

  mem_access_unit #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .in_result (in_result),
    .in_rt_val (in_rt_val),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .wb_valid  (wb_valid),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Output monitor: any wb_valid/err strobe must match the oldest expected event.
  always @(negedge clk) begin
    if (rst_n && (wb_valid || err)) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got wb_valid=%b err=%b reg=%0d data=%h expected no event",
                 wb_valid, err, wb_reg, wb_data);
      end else begin
        event_t e;
        e = sb_q.pop_front();
        chk("sb_err", {31'd0, err}, {31'd0, e.is_err});
        chk("sb_wb_valid", {31'd0, wb_valid}, {31'd0, !e.is_err});
        if (!e.is_err) begin
          chk("sb_wb_reg", {27'd0, wb_reg}, {27'd0, e.rg});
          chk("sb_wb_data", wb_data, e.data);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Single-cycle instruction: accept, then the event (if any) follows one cycle later.
  task automatic apply_vec(input vec_t v);
    event_t e;
    if (v.exp_wb || v.exp_err) begin
      e.is_err = v.exp_err;
      e.rg     = v.exp_reg;
      e.data   = v.exp_data;
      sb_q.push_back(e);
    end
    in_valid  = 1'b1;
    in_inst   = v.inst;
    in_result = v.result;
    in_rt_val = v.rt_val;
    chk("vec_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("vec_sb_drained", sb_q.size(), 32'd0);
    chk("vec_mem_req", {31'd0, mem_req}, 32'd0);
    step();
    chk("vec_mem_req_after", {31'd0, mem_req}, 32'd0);
    chk("vec_in_ready_after", {31'd0, in_ready}, 32'd1);
  endtask

  // lw/sw with the ack arriving 'delay' cycles after mem_req first rises.
  task automatic mem_txn(input bit is_lw, input logic [31:0] addr, input logic [4:0] rt,
                         input logic [31:0] val, input int delay);
    event_t e;
    if (is_lw && rt != 5'd0) begin
      e.is_err = 1'b0;
      e.rg     = rt;
      e.data   = val;
      sb_q.push_back(e);
    end
    in_valid  = 1'b1;
    in_inst   = {(is_lw ? OP_LW : OP_SW), 5'd2, rt, 16'h0040};
    in_result = addr;
    in_rt_val = val;
    chk("txn_in_ready_idle", {31'd0, in_ready}, 32'd1);
    step();
    in_valid  = 1'b0;
    in_result = 32'hFFFF_FFFF;
    in_rt_val = 32'hFFFF_FFFF;
    for (int i = 0; i <= delay; i++) begin
      chk("txn_mem_req", {31'd0, mem_req}, 32'd1);
      chk("txn_mem_we", {31'd0, mem_we}, {31'd0, !is_lw});
      chk("txn_mem_addr", mem_addr, addr);
      chk("txn_in_ready_busy", {31'd0, in_ready}, 32'd0);
      if (!is_lw) chk("txn_mem_wdata", mem_wdata, val);
      if (i == delay) begin
        mem_ack   = 1'b1;
        mem_rdata = val;
      end
      step();
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
    end
    chk("txn_mem_req_drop", {31'd0, mem_req}, 32'd0);
    if (is_lw) begin
      chk("txn_in_ready_wb", {31'd0, in_ready}, 32'd0);
      step();
    end
    chk("txn_in_ready_done", {31'd0, in_ready}, 32'd1);
    chk("txn_sb_drained", sb_q.size(), 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    int n;
    event_t e;

    vecs[0] = '{{OP_RTYPE, 5'd1, 5'd2, 5'd5, 5'd0, 6'h20}, 32'h0000_0007, 32'h0, 1, 0, 5'd5, 32'h0000_0007};
    vecs[1] = '{{OP_RTYPE, 5'd3, 5'd4, 5'd31, 5'd0, 6'h22}, 32'hFFFF_FFFF, 32'h0, 1, 0, 5'd31, 32'hFFFF_FFFF};
    vecs[2] = '{{OP_RTYPE, 5'd3, 5'd4, 5'd0, 5'd0, 6'h20}, 32'h0000_0055, 32'h0, 0, 0, 5'd0, 32'h0};
    vecs[3] = '{{6'b000010, 26'h0000123}, 32'h0000_0100, 32'h0, 0, 0, 5'd0, 32'h0};
    vecs[4] = '{{OP_LW, 5'd2, 5'd8, 16'h0}, 32'h0000_0102, 32'h0, 0, 1, 5'd0, 32'h0};
    vecs[5] = '{{OP_SW, 5'd2, 5'd9, 16'h0}, 32'h0000_0201, 32'hCAFE_0001, 0, 1, 5'd0, 32'h0};
    vecs[6] = '{{OP_RTYPE, 5'd7, 5'd6, 5'd1, 5'd0, 6'h25}, 32'hA5A5_0001, 32'h0, 1, 0, 5'd1, 32'hA5A5_0001};
    vecs[7] = '{{OP_LW, 5'd2, 5'd0, 16'h0}, 32'h0000_0003, 32'h0, 0, 1, 5'd0, 32'h0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_inst   = 32'h0;
    in_result = 32'h0;
    in_rt_val = 32'h0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    step();
    step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_reg", {27'd0, wb_reg}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) apply_vec(vecs[i]);

    // Load and store scenarios, including same-cycle ack and ack on the last allowed cycle
    mem_txn(1'b1, 32'h0000_0100, 5'd8, 32'hDEAD_BEEF, 2);
    mem_txn(1'b0, 32'h0000_0204, 5'd3, 32'h1234_5678, 1);
    mem_txn(1'b1, 32'h0000_0A00, 5'd4, 32'h0BAD_F00D, 0);
    mem_txn(1'b1, 32'h0000_0C08, 5'd6, 32'h5555_AAAA, TIMEOUT - 1);
    mem_txn(1'b1, 32'h0000_0010, 5'd0, 32'h7777_7777, 1);

    // Timeout: mem_req must stay up for exactly TIMEOUT cycles, then err pulses
    e.is_err = 1'b1;
    e.rg     = 5'd0;
    e.data   = 32'h0;
    sb_q.push_back(e);
    in_valid  = 1'b1;
    in_inst   = {OP_LW, 5'd2, 5'd9, 16'h0};
    in_result = 32'h0000_0300;
    step();
    in_valid = 1'b0;
    n = 0;
    while (mem_req && n < 3 * TIMEOUT) begin
      n++;
      step();
    end
    chk("timeout_req_cycles", n, TIMEOUT);
    chk("timeout_sb_drained", sb_q.size(), 32'd0);
    chk("timeout_in_ready", {31'd0, in_ready}, 32'd1);
    apply_vec(vecs[0]);

    // mem_ack while idle has no effect
    mem_ack   = 1'b1;
    mem_rdata = 32'h1111_2222;
    step();
    step();
    mem_ack = 1'b0;
    chk("idle_ack_mem_req", {31'd0, mem_req}, 32'd0);
    chk("idle_ack_in_ready", {31'd0, in_ready}, 32'd1);

    // Reset during ACCESS aborts the load with no writeback
    in_valid  = 1'b1;
    in_inst   = {OP_LW, 5'd2, 5'd3, 16'h0};
    in_result = 32'h0000_0400;
    step();
    in_valid = 1'b0;
    step();
    chk("abort_mem_req_before", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_mem_req_async", {31'd0, mem_req}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_mem_req", {31'd0, mem_req}, 32'd0);
    chk("abort_wb_valid", {31'd0, wb_valid}, 32'd0);
    apply_vec(vecs[1]);

    step();
    chk("final_sb_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
